// File: rtl/alu_op_scheduler_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | alu_op_scheduler_if: requester, response and ALU bus bundle         |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface alu_op_scheduler_if #(
  parameter int W   = 4,
  parameter int OPW = 3,
  parameter int RW  = 8
);
  logic           req0_valid;
  logic           req0_ready;
  logic [OPW-1:0] req0_op;
  logic [W-1:0]   req0_a;
  logic [W-1:0]   req0_b;
  logic           rsp0_valid;
  logic           rsp0_ready;
  logic [RW-1:0]  rsp0_data;

  logic           req1_valid;
  logic           req1_ready;
  logic [OPW-1:0] req1_op;
  logic [W-1:0]   req1_a;
  logic [W-1:0]   req1_b;
  logic           rsp1_valid;
  logic           rsp1_ready;
  logic [RW-1:0]  rsp1_data;

  logic [OPW-1:0] alu_op;
  logic [W-1:0]   alu_a;
  logic [W-1:0]   alu_b;
  logic           alu_start;
  logic [RW-1:0]  alu_result;

  // master: requesters plus the ALU datapath
  modport master (
    output req0_valid, req0_op, req0_a, req0_b, rsp0_ready,
    output req1_valid, req1_op, req1_a, req1_b, rsp1_ready,
    output alu_result,
    input  req0_ready, rsp0_valid, rsp0_data,
    input  req1_ready, rsp1_valid, rsp1_data,
    input  alu_op, alu_a, alu_b, alu_start
  );

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b, rsp0_ready,
    input  req1_valid, req1_op, req1_a, req1_b, rsp1_ready,
    input  alu_result,
    output req0_ready, rsp0_valid, rsp0_data,
    output req1_ready, rsp1_valid, rsp1_data,
    output alu_op, alu_a, alu_b, alu_start
  );
endinterface
`default_nettype wire

// File: rtl/alu_op_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | alu_op_scheduler: round-robin sharing of one ALU by two requesters  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module alu_op_scheduler #(
  parameter int W       = 4,
  parameter int OPW     = 3,
  parameter int RW      = 8,
  parameter int ALU_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  alu_op_scheduler_if.slave bus,
  output logic             busy,
  output logic             grant_id
);

  localparam logic [2:0] c_lat = 3'(ALU_LAT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic           last_q, last_d;
  logic           grant_q, grant_d;
  logic [OPW-1:0] op_q, op_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic [2:0]     cnt_q, cnt_d;
  logic [RW-1:0]  result_q, result_d;
  logic           win;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      last_q   <= 1'b1;
      grant_q  <= 1'b0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      grant_q  <= grant_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  // On a tie the requester that was not served last wins.
  always_comb begin
    if (bus.req0_valid && bus.req1_valid) win = ~last_q;
    else                                  win = bus.req1_valid;
  end

  always_comb begin
    state_d        = state_q;
    last_d         = last_q;
    grant_d        = grant_q;
    op_d           = op_q;
    a_d            = a_q;
    b_d            = b_q;
    cnt_d          = cnt_q;
    result_d       = result_q;
    bus.req0_ready = 1'b0;
    bus.req1_ready = 1'b0;
    bus.rsp0_valid = 1'b0;
    bus.rsp1_valid = 1'b0;
    bus.alu_start  = 1'b0;
    case (state_q)
      S_IDLE: begin
        // rst gates ready so a request is never acknowledged while held in reset
        if (!rst && ena && (bus.req0_valid || bus.req1_valid)) begin
          bus.req0_ready = ~win;
          bus.req1_ready = win;
          grant_d        = win;
          op_d           = win ? bus.req1_op : bus.req0_op;
          a_d            = win ? bus.req1_a  : bus.req0_a;
          b_d            = win ? bus.req1_b  : bus.req0_b;
          state_d        = S_ISSUE;
        end
      end
      S_ISSUE: begin
        bus.alu_start = 1'b1;
        if (ALU_LAT == 0) begin
          result_d = bus.alu_result;
          state_d  = S_RESP;
        end else begin
          cnt_d   = c_lat;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == 3'd1) begin
          result_d = bus.alu_result;
          state_d  = S_RESP;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      S_RESP: begin
        bus.rsp0_valid = ~grant_q;
        bus.rsp1_valid = grant_q;
        if (grant_q ? bus.rsp1_ready : bus.rsp0_ready) begin
          last_d  = grant_q;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Operand registers change only on acceptance, so they hold between ops.
  assign bus.alu_op    = op_q;
  assign bus.alu_a     = a_q;
  assign bus.alu_b     = b_q;
  assign bus.rsp0_data = result_q;
  assign bus.rsp1_data = result_q;
  assign busy          = (state_q != S_IDLE);
  assign grant_id      = grant_q;

endmodule
`default_nettype wire
